// File: rtl/text_engine_attr_pkg.sv
// Shared definitions for the attribute text engine: VRAM word layout,
// default 480x272 LCD timing and cursor underline geometry.
package text_pkg;

  localparam int CHAR_LSB  = 0;
  localparam int FG_LSB    = 8;
  localparam int BG_LSB    = 12;
  localparam int BLINK_BIT = 15;
  localparam int CHAR_BITS = 8;
  localparam int FG_BITS   = 4;
  localparam int BG_BITS   = 3;

  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FP     = 2;
  localparam int DEF_H_SYNC   = 41;
  localparam int DEF_H_BP     = 2;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FP     = 2;
  localparam int DEF_V_SYNC   = 10;
  localparam int DEF_V_BP     = 2;

  localparam int CURSOR_H = 2;

  typedef struct packed {
    logic [FG_BITS-1:0] fg;
    logic [BG_BITS-1:0] bg;
    logic               blink;
  } cell_attr_t;

  function automatic cell_attr_t unpack_attr(input logic [15:0] word);
    cell_attr_t a;
    a.fg    = word[FG_LSB +: FG_BITS];
    a.bg    = word[BG_LSB +: BG_BITS];
    a.blink = word[BLINK_BIT];
    return a;
  endfunction

endpackage

// File: rtl/text_engine_attr_delay_line.sv
// Parametrised shift-register delay used to keep sideband signals aligned
// with the VRAM / font ROM pipeline.
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign o_q = stage_q[DEPTH-1];

endmodule

// File: rtl/text_engine_attr.sv
// Text-mode LCD renderer with per-cell colour attributes, blink and a
// blinking underline cursor; three-stage pipeline from counters to o_color.
module text_engine_attr
  import text_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter int   CHAR_W      = 8,
  parameter int   CHAR_H      = 16,
  parameter int   COL_W       = 6,
  parameter int   ROW_W       = 5,
  parameter int   BLINK_LOG2  = 5,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic                                            i_clk,
  input  logic                                            i_rst,
  input  logic                                            i_cursor_en,
  input  logic [COL_W-1:0]                                i_cursor_x,
  input  logic [ROW_W-1:0]                                i_cursor_y,
  output logic [ROW_W+COL_W-1:0]                          o_video_addr,
  input  logic [15:0]                                     i_vram_data,
  output logic [CHAR_BITS+$clog2(CHAR_H)+$clog2(CHAR_W)-1:0] o_font_addr,
  input  logic                                            i_font_px,
  output logic [3:0]                                      o_color,
  output logic                                            o_LCD_HSYNC,
  output logic                                            o_LCD_VSYNC,
  output logic                                            o_LCD_DEN,
  output logic                                            o_LCD_CLK
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int CXW     = $clog2(CHAR_W);
  localparam int CYW     = $clog2(CHAR_H);
  localparam int FW      = BLINK_LOG2 + 1;
  localparam int unsigned COLS = H_ACTIVE / CHAR_W;
  localparam int unsigned ROWS = V_ACTIVE / CHAR_H;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [FW-1:0] frame_q, frame_d;

  always_comb begin
    x_d     = x_q + 1'b1;
    y_d     = y_q;
    frame_d = frame_q;
    if (x_q == XW'(H_TOTAL - 1)) begin
      x_d = '0;
      if (y_q == YW'(V_TOTAL - 1)) begin
        y_d     = '0;
        frame_d = frame_q + 1'b1;
      end else begin
        y_d = y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
    end
  end

  // Stage 0: cell/glyph coordinates, timing flags and cursor match.
  logic [CXW-1:0] x_char;
  logic [CYW-1:0] y_char;
  logic [XW-1:0]  x_cell_full;
  logic [YW-1:0]  y_cell_full;
  logic           hde, vde, hsync_act, vsync_act, cursor_hit;

  assign x_char      = x_q[CXW-1:0];
  assign y_char      = y_q[CYW-1:0];
  assign x_cell_full = x_q >> CXW;
  assign y_cell_full = y_q >> CYW;

  assign o_video_addr = {ROW_W'(y_cell_full), COL_W'(x_cell_full)};

  assign hde       = x_q < XW'(H_ACTIVE);
  assign vde       = y_q < YW'(V_ACTIVE);
  assign hsync_act = (x_q >= XW'(H_ACTIVE + H_FP)) && (x_q < XW'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_act = (y_q >= YW'(V_ACTIVE + V_FP)) && (y_q < YW'(V_ACTIVE + V_FP + V_SYNC));

  // Full-width compare plus range check: off-screen cursors never alias onto blanking cells.
  assign cursor_hit = i_cursor_en
                   && (32'(i_cursor_x) < COLS) && (32'(i_cursor_y) < ROWS)
                   && (32'(x_cell_full) == 32'(i_cursor_x))
                   && (32'(y_cell_full) == 32'(i_cursor_y))
                   && (y_char >= CYW'(CHAR_H - CURSOR_H));

  // Stage 1: VRAM word valid; form font address and register attributes.
  logic [CXW-1:0] x_char_s1;
  logic [CYW-1:0] y_char_s1;

  delay_line #(.WIDTH(CXW + CYW), .DEPTH(1)) u_char_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   ({y_char, x_char}),
    .o_q   ({y_char_s1, x_char_s1})
  );

  assign o_font_addr = {i_vram_data[CHAR_LSB +: CHAR_BITS], y_char_s1, x_char_s1};

  cell_attr_t attr_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) attr_q <= '0;
    else       attr_q <= unpack_attr(i_vram_data);
  end

  logic cursor_s2;

  delay_line #(.WIDTH(1), .DEPTH(2)) u_cursor_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (cursor_hit),
    .o_q   (cursor_s2)
  );

  logic hsync_s2, vsync_s2, den_s2;

  delay_line #(.WIDTH(3), .DEPTH(2)) u_sync_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   ({hsync_act, vsync_act, hde && vde}),
    .o_q   ({hsync_s2, vsync_s2, den_s2})
  );

  // Stage 2: font pixel valid; blink/cursor resolution and colour mux.
  logic       phase, glyph, cursor_on;
  logic [3:0] color_d;

  assign phase     = frame_q[BLINK_LOG2];
  assign glyph     = i_font_px && !(attr_q.blink && !phase);
  assign cursor_on = cursor_s2 && phase;

  always_comb begin
    color_d = 4'h0;
    if (den_s2) color_d = (glyph || cursor_on) ? attr_q.fg : {1'b0, attr_q.bg};
  end

  logic [3:0] color_q;
  logic       den_q, hsync_q, vsync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      color_q <= 4'h0;
      den_q   <= 1'b0;
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
    end else begin
      color_q <= color_d;
      den_q   <= den_s2;
      hsync_q <= hsync_s2 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_q <= vsync_s2 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  assign o_color     = color_q;
  assign o_LCD_DEN   = den_q;
  assign o_LCD_HSYNC = hsync_q;
  assign o_LCD_VSYNC = vsync_q;
  assign o_LCD_CLK   = i_clk;

endmodule

// File: tb/tb_text_engine_attr.sv
// Self-checking bench for text_engine_attr using a reduced timing geometry
// so several frames (and a blink wrap) fit in a short run.
module tb_text_engine_attr;

  localparam int HA = 32, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 32, VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int CW = 8, CH = 16, COLW = 6, ROWW = 5, BL = 1;
  localparam logic SYNC_ACT = 1'b0;
  localparam int LIMIT = 3 * HT * VT;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cursorEn;
  logic [COLW-1:0]  cursorX;
  logic [ROWW-1:0]  cursorY;
  logic [ROWW+COLW-1:0] videoAddr;
  logic [15:0]      vramData;
  logic [14:0]      fontAddr;
  logic             fontPx;
  logic [3:0]       color;
  logic             hsync, vsync, den, lcdClk;

  text_engine_attr #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CHAR_W(CW), .CHAR_H(CH), .COL_W(COLW), .ROW_W(ROWW),
    .BLINK_LOG2(BL), .SYNC_ACTIVE(SYNC_ACT)
  ) dut (
    .i_clk(clock), .i_rst(reset),
    .i_cursor_en(cursorEn), .i_cursor_x(cursorX), .i_cursor_y(cursorY),
    .o_video_addr(videoAddr), .i_vram_data(vramData),
    .o_font_addr(fontAddr), .i_font_px(fontPx),
    .o_color(color), .o_LCD_HSYNC(hsync), .o_LCD_VSYNC(vsync),
    .o_LCD_DEN(den), .o_LCD_CLK(lcdClk)
  );

  always #5 clock = ~clock;

  logic [15:0] vram [0:2047];
  logic [7:0]  aRows [0:15];

  function automatic logic fontBit(input logic [7:0] c, input logic [3:0] yc, input logic [2:0] xc);
    logic [7:0] row;
    row = (c == 8'h41) ? aRows[yc] : (c ^ {yc, yc});
    return row[3'd7 - xc];
  endfunction

  always @(posedge clock) begin
    vramData <= vram[videoAddr];
    fontPx   <= fontBit(fontAddr[14:7], fontAddr[6:3], fontAddr[2:0]);
  end

  int compares = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input int got, input int want);
    compares++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [COLW-1:0] cx, input logic [ROWW-1:0] cy);
    cursorEn = en;
    cursorX  = cx;
    cursorY  = cy;
  endtask

  typedef struct {
    int         x;
    int         y;
    int         frame;
    logic [6:0] pix;
  } exp_t;

  exp_t sbQ[$];

  int          mx, my, frameNo, cyc, lastX, lastY, lastF;
  logic [BL:0] mf;
  int          lastHsEdge, lastVsEdge, denCnt, denLines;
  logic        hsSeen, prevHsAct, prevVsAct;

  function automatic logic [6:0] expPix(input int px, input int py, input logic [BL:0] fc);
    logic de, hs, vs, ph, glyph, cur;
    logic [15:0] w;
    logic [3:0] col;
    int cx, cy;
    de  = (px < HA) && (py < VA);
    hs  = (px >= HA + HFP && px < HA + HFP + HS) ? SYNC_ACT : !SYNC_ACT;
    vs  = (py >= VA + VFP && py < VA + VFP + VS) ? SYNC_ACT : !SYNC_ACT;
    ph  = fc[BL];
    col = 4'h0;
    if (de) begin
      cx    = px / CW;
      cy    = py / CH;
      w     = vram[cy * 64 + cx];
      glyph = fontBit(w[7:0], 4'(py % CH), 3'(px % CW));
      if (w[15] && !ph) glyph = 1'b0;
      cur = cursorEn && int'(cursorX) == cx && int'(cursorY) == cy
            && cx < HA / CW && cy < VA / CH && (py % CH) >= CH - 2 && ph;
      col = (glyph || cur) ? w[11:8] : {1'b0, w[14:12]};
    end
    return {de, hs, vs, col};
  endfunction

  task automatic resetModel();
    exp_t idle;
    sbQ.delete();
    idle = '{x: -1, y: -1, frame: -1, pix: {1'b0, !SYNC_ACT, !SYNC_ACT, 4'h0}};
    repeat (3) sbQ.push_back(idle);
    mx = 0; my = 0; mf = '0; frameNo = 0; cyc = -1;
    lastX = -1; lastY = -1; lastF = -1;
    lastHsEdge = -1; lastVsEdge = -1; denCnt = 0; denLines = 0;
    hsSeen = 1'b0; prevHsAct = 1'b0; prevVsAct = 1'b0;
  endtask

  // One pixel clock: pop/compare the oldest expectation, track sync/DEN
  // periods, then push the expectation for the pixel now in stage 0.
  task automatic stepCycle();
    exp_t cur;
    logic hsAct, vsAct;
    @(negedge clock);
    cyc++;
    cur = sbQ.pop_front();
    lastX = cur.x; lastY = cur.y; lastF = cur.frame;
    checkOutput($sformatf("sb f%0d x%0d y%0d {de,hs,vs,color}", cur.frame, cur.x, cur.y),
                int'({den, hsync, vsync, color}), int'(cur.pix));
    hsAct = (hsync == SYNC_ACT);
    vsAct = (vsync == SYNC_ACT);
    if (den) denCnt++;
    if (hsAct && !prevHsAct) begin
      if (!hsSeen) begin
        hsSeen = 1'b1;
        checkOutput("firstHsyncDelay", cyc, 3 + HA + HFP);
      end else begin
        checkOutput("hsyncPeriod", cyc - lastHsEdge, HT);
      end
      lastHsEdge = cyc;
      if (denCnt != 0) begin
        checkOutput("denPerLine", denCnt, HA);
        denLines++;
      end
      denCnt = 0;
    end
    if (vsAct && !prevVsAct) begin
      if (lastVsEdge >= 0) checkOutput("vsyncPeriod", cyc - lastVsEdge, HT * VT);
      checkOutput("denLinesPerFrame", denLines, VA);
      denLines   = 0;
      lastVsEdge = cyc;
    end
    prevHsAct = hsAct;
    prevVsAct = vsAct;
    sbQ.push_back('{x: mx, y: my, frame: frameNo, pix: expPix(mx, my, mf)});
    mx++;
    if (mx == HT) begin
      mx = 0;
      my++;
      if (my == VT) begin
        my = 0;
        mf = mf + 1'b1;
        frameNo++;
      end
    end
  endtask

  typedef struct {
    int              frame;
    int              x;
    int              y;
    logic [COLW-1:0] curX;
    logic [3:0]      expColor;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    int n;
    for (int a = 0; a < 2048; a++) vram[a] = 16'h5E00 | 16'(a & 8'hFF);
    vram[0]  = 16'h1F41;
    vram[1]  = 16'hAA41;
    vram[67] = 16'h3C41;
    for (int r = 0; r < 16; r++) aRows[r] = 8'h00;
    aRows[2] = 8'h18; aRows[3] = 8'h3C; aRows[4] = 8'h66; aRows[5] = 8'h66;
    aRows[6] = 8'h7E; aRows[7] = 8'h66; aRows[8] = 8'h66; aRows[9] = 8'h66;

    vecs[0]  = '{0,  0,  2, 6'd3,  4'h1};
    vecs[1]  = '{0,  3,  2, 6'd3,  4'hF};
    vecs[2]  = '{0, 11,  2, 6'd3,  4'h2};
    vecs[3]  = '{0,  0,  4, 6'd3,  4'h1};
    vecs[4]  = '{0,  1,  4, 6'd3,  4'hF};
    vecs[5]  = '{0,  6,  6, 6'd3,  4'hF};
    vecs[6]  = '{0,  7,  6, 6'd3,  4'h1};
    vecs[7]  = '{0, 24, 30, 6'd3,  4'h3};
    vecs[8]  = '{0, 31, 31, 6'd3,  4'h3};
    vecs[9]  = '{2,  8,  2, 6'd3,  4'h2};
    vecs[10] = '{2, 11,  2, 6'd3,  4'hA};
    vecs[11] = '{2, 24, 29, 6'd3,  4'h3};
    vecs[12] = '{2, 24, 30, 6'd3,  4'hC};
    vecs[13] = '{2, 31, 31, 6'd3,  4'hC};
    vecs[14] = '{4, 11,  2, 6'd3,  4'h2};
    vecs[15] = '{4, 24, 31, 6'd3,  4'h3};
    vecs[16] = '{6, 24, 30, 6'd63, 4'h3};
    vecs[17] = '{6, 31, 31, 6'd63, 4'h3};

    applyStimulus(1'b1, 6'd3, 5'd1);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("resetColor", color, 0);
    checkOutput("resetDen", den, 0);
    checkOutput("resetHsync", hsync, !SYNC_ACT);
    checkOutput("resetVsync", vsync, !SYNC_ACT);

    @(posedge clock);
    #1 reset = 1'b0;
    resetModel();

    n = 0;
    while (!(my == 0 && mx == 20) && n < HT) begin
      stepCycle();
      n++;
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncResetColor", color, 0);
    checkOutput("asyncResetDen", den, 0);
    checkOutput("asyncResetHsync", hsync, !SYNC_ACT);
    checkOutput("asyncResetVsync", vsync, !SYNC_ACT);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    resetModel();

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].curX != cursorX) begin
        n = 0;
        while (!(frameNo == vecs[i].frame - 1 && my >= VA) && n < LIMIT) begin
          stepCycle();
          n++;
        end
        checkOutput($sformatf("vec%0d vblankReached", i), int'(n < LIMIT), 1);
        applyStimulus(cursorEn, vecs[i].curX, cursorY);
      end
      n = 0;
      while (!(lastF == vecs[i].frame && lastX == vecs[i].x && lastY == vecs[i].y) && n < LIMIT) begin
        stepCycle();
        n++;
      end
      if (n >= LIMIT)
        checkOutput($sformatf("vec%0d pixelReached", i), 0, 1);
      else
        checkOutput($sformatf("vec%0d f%0d x%0d y%0d color", i, vecs[i].frame, vecs[i].x, vecs[i].y),
                    color, vecs[i].expColor);
    end

    n = 0;
    while (!(frameNo == 7 && my >= 2) && n < LIMIT) begin
      stepCycle();
      n++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", compares, failures);
    $finish;
  end

endmodule

// File: doc/text_engine_attr.md
# text_engine_attr

Parametrised text-mode renderer, successor to the monochrome 8x16 text engine. It integrates H/V timing, scans a character-plus-attribute VRAM, and fetches glyph pixels from an external font ROM. Each cell gets a 4-bit colour index from per-cell foreground/background attributes, per-cell blink and a hardware blinking underline cursor. It sits between the VRAM/font ROM and the LCD pins, driving sync, DEN and a colour index for the palette stage.

## Interface
- H_ACTIVE, 480, active pixels per line
- H_FP / H_SYNC / H_BP, 2 / 41 / 2, horizontal porch/sync widths (clocks)
- V_ACTIVE, 272, active lines per frame
- V_FP / V_SYNC / V_BP, 2 / 10 / 2, vertical porch/sync widths (lines)
- CHAR_W, 8, glyph width, power of two
- CHAR_H, 16, glyph height, power of two
- COL_W / ROW_W, 6 / 5, cell-index widths; VRAM address width = ROW_W+COL_W
- BLINK_LOG2, 5, blink phase = frame_cnt[BLINK_LOG2] (toggles every 32 frames)
- SYNC_ACTIVE, 1'b0, asserted level of HSYNC/VSYNC

Ports:
- i_clk  in  1  pixel clock (12 MHz)
- i_rst  in  1  reset; one clock, asynchronous, active-high
- i_cursor_en  in  1  cursor enable
- i_cursor_x  in  COL_W  cursor column
- i_cursor_y  in  ROW_W  cursor row
- o_video_addr  out  ROW_W+COL_W  VRAM address = {y_cell, x_cell}
- i_vram_data  in  16  [7:0] char code, [11:8] fg index, [14:12] bg index, [15] blink; valid one clock after address
- o_font_addr  out  8+log2(CHAR_H)+log2(CHAR_W)  {char, y_char, x_char}
- i_font_px  in  1  glyph pixel; valid one clock after o_font_addr
- o_color  out  4  palette index
- o_LCD_HSYNC / o_LCD_VSYNC / o_LCD_DEN  out  1  LCD controls, aligned with o_color
- o_LCD_CLK  out  1  = i_clk

## Operation
- x counter 0..H_TOTAL-1, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; wraps to 0. y increments on x wrap, 0..V_TOTAL-1.
- hde = x < H_ACTIVE; vde = y < V_ACTIVE. HSYNC asserted for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; VSYNC is analogous on y.
- x_cell = x / CHAR_W, x_char = x % CHAR_W; y_cell / y_char likewise with CHAR_H. Cell fields are truncated to COL_W/ROW_W.
- frame_cnt (BLINK_LOG2+1 bits) increments when y wraps to 0 and wraps freely.
- Pixel colour at output stage:
  - glyph = i_font_px, XOR blink-hide: glyph forced 0 if attr[15] and blink phase = 0.
  - cursor = i_cursor_en, cell matches (cursor_x, cursor_y), y_char >= CHAR_H-2, and blink phase = 1. Cursor overrides to fg.
  - o_color = (glyph|cursor) ? {0,fg} | fg : {1'b0,bg}. fg is a full 4-bit index; bg is zero-extended 3 bits.
  - Outside DEN, o_color = 0.
- Cursor coordinates beyond the visible cells never match, so no cursor is drawn; no error flag is raised.
- Reset (async): x, y, frame_cnt = 0. All pipeline registers clear: o_color = 0, o_LCD_DEN = 0, HSYNC/VSYNC = !SYNC_ACTIVE. On release, counting starts at x=0, y=0 and the first frame is full length.

## Timing
- Stage 0: x/y registers drive o_video_addr combinationally.
- Stage 1: i_vram_data valid. o_font_addr is formed combinationally from i_vram_data and x_char/y_char delayed by 1. Attributes and the cursor-match flag are registered.
- Stage 2: i_font_px valid. The colour mux is registered into o_color.
- Total latency is 3 clocks from counter to o_color. HSYNC, VSYNC and DEN are delayed by exactly 3 clocks, so they stay aligned with o_color.
- The cursor compare uses stage-0 cell coordinates, pipelined with the data.
- The blink phase is sampled per pixel. A frame_cnt change at y wrap falls inside blanking, so there is no mid-frame tearing.

## Structure
- Shared package text_pkg:
  - VRAM word field offsets (CHAR_LSB, FG_LSB, BG_LSB, BLINK_BIT)
  - default 480x272 timing constants
  - cursor underline height (2)
- One sub-module, delay_line #(WIDTH, DEPTH): parametrised shift-register delay. It replaces the fixed 1/2-tic delay cells and is used for syncs, DEN, x_char/y_char and the cursor flag.
- The font ROM stays external (instantiated by the top).

## Test plan
- Reset asserted mid-line at x=100 -> outputs go immediately to color=0, DEN=0, syncs inactive. After release, the first HSYNC edge appears 3+H_ACTIVE+H_FP clocks later.
- Free run of one frame -> HSYNC period 525 clocks, VSYNC period 286 lines, DEN high 480 clocks per active line, 272 lines per frame.
- Cell (0,0)=0x41, fg=0xF, bg=0x1, font model returns a known 'A' -> active pixels give 0xF on glyph bits and 0x1 elsewhere, 3 clocks after address 0.
- Cursor enabled at (59,16) -> lines 270-271, x 472-479 show the fg index during phase 1 and the underlying glyph during phase 0.
- Cursor at x=63 (out of range) -> no cursor pixel anywhere in the frame.
- Blink attribute set on a cell -> the glyph is visible when frame_cnt[5]=1 and shows only bg when it is 0. The phase toggles after 32 frames; frame_cnt wrap from 63 to 0 causes no glitch.
